order_sort_4: RTL and testbench



---
 rtl/order_sort_pkg.sv | 9 +
 rtl/order_cmp_swap.sv | 32 +++
 rtl/order_sort_4.sv | 92 +++++++++
 tb/tb_order_sort_4.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/order_sort_pkg.sv
// Shared constants for the 4-input leaf sorting network.
package order_sort_pkg;

    // Register stages between the input sample and the sorted output.
    localparam int ORDER_SORT_LATENCY       = 3;
    // Default word width of the sorter datapath.
    localparam int ORDER_SORT_DEFAULT_DSIZE = 8;

endpackage

// File: rtl/order_cmp_swap.sv
// Registered compare-exchange cell: lo receives the smaller word and hi the
// larger one. The comparison is unsigned over the full width. Equal words are
// never swapped.
module order_cmp_swap
    import order_sort_pkg::*;
#(
    parameter int DSIZE = ORDER_SORT_DEFAULT_DSIZE
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic [DSIZE-1:0] lo,
    output logic [DSIZE-1:0] hi
);

    logic swap;

    assign swap = (a > b);

    // Capture the ordered pair; async reset clears both words.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= swap ? b : a;
            hi <= swap ? a : b;
        end
    end

endmodule

// File: rtl/order_sort_4.sv
// Pipelined 4-input ascending sorter (5 compare-exchange cells, 3 stages).
// Optional feature macro: ORDER_SORT_VALID_EN adds in_valid/out_valid as a
// sideband qualifier delayed to match the data pipeline.
module order_sort_4
    import order_sort_pkg::*;
#(
    parameter int DSIZE = ORDER_SORT_DEFAULT_DSIZE
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [DSIZE-1:0] indata0,
    input  logic [DSIZE-1:0] indata1,
    input  logic [DSIZE-1:0] indata2,
    input  logic [DSIZE-1:0] indata3,
    output logic [DSIZE-1:0] outdata0,
    output logic [DSIZE-1:0] outdata1,
    output logic [DSIZE-1:0] outdata2,
    output logic [DSIZE-1:0] outdata3
`ifdef ORDER_SORT_VALID_EN
    ,
    input  logic             in_valid,
    output logic             out_valid
`endif
);

    logic [DSIZE-1:0] lane0_p1, lane1_p1, lane2_p1, lane3_p1;
    logic [DSIZE-1:0] lane0_p2, lane1_p2, lane2_p2, lane3_p2;
    logic [DSIZE-1:0] lane0_p3, lane1_p3, lane2_p3, lane3_p3;

    // Stage 1: order each input pair, (0,1) and (2,3).
    order_cmp_swap #(.DSIZE(DSIZE)) u_cs_01 (
        .clock(clock), .rst(rst), .a(indata0), .b(indata1),
        .lo(lane0_p1), .hi(lane1_p1)
    );

    order_cmp_swap #(.DSIZE(DSIZE)) u_cs_23 (
        .clock(clock), .rst(rst), .a(indata2), .b(indata3),
        .lo(lane2_p1), .hi(lane3_p1)
    );

    // Stage 2: merge the pairs, which settles the global min and max.
    order_cmp_swap #(.DSIZE(DSIZE)) u_cs_02 (
        .clock(clock), .rst(rst), .a(lane0_p1), .b(lane2_p1),
        .lo(lane0_p2), .hi(lane2_p2)
    );

    order_cmp_swap #(.DSIZE(DSIZE)) u_cs_13 (
        .clock(clock), .rst(rst), .a(lane1_p1), .b(lane3_p1),
        .lo(lane1_p2), .hi(lane3_p2)
    );

    // Stage 3: order the two middle words.
    order_cmp_swap #(.DSIZE(DSIZE)) u_cs_12 (
        .clock(clock), .rst(rst), .a(lane1_p2), .b(lane2_p2),
        .lo(lane1_p3), .hi(lane2_p3)
    );

    // Stage 3 pass-through: min and max are already final, so they are only
    // delayed to stay aligned with the middle pair.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lane0_p3 <= '0;
            lane3_p3 <= '0;
        end else begin
            lane0_p3 <= lane0_p2;
            lane3_p3 <= lane3_p2;
        end
    end

    assign outdata0 = lane0_p3;
    assign outdata1 = lane1_p3;
    assign outdata2 = lane2_p3;
    assign outdata3 = lane3_p3;

`ifdef ORDER_SORT_VALID_EN
    // One flop per data stage. Data flops update every cycle regardless, so
    // the qualifier only rides alongside the data.
    logic [ORDER_SORT_LATENCY-1:0] vld_sr;

    // Shift the input qualifier through the stages; reset drops in-flight sets.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[ORDER_SORT_LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = vld_sr[ORDER_SORT_LATENCY-1];
`endif

endmodule

// File: tb/tb_order_sort_4.sv
// Bench for order_sort_4: directed vector table, multi-cycle reset and latency
// sequences, a random streaming scoreboard, and a 64-bit instance.
// The optional valid sideband is exercised when ORDER_SORT_VALID_EN is defined.
module tb_order_sort_4;
    import order_sort_pkg::*;

    localparam int LAG = ORDER_SORT_LATENCY - 1;  // edges after the sampling edge

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst;
    logic [7:0] in0, in1, in2, in3;
    logic [7:0] out0, out1, out2, out3;

    logic [63:0] w_in0, w_in1, w_in2, w_in3;
    logic [63:0] w_out0, w_out1, w_out2, w_out3;

`ifdef ORDER_SORT_VALID_EN
    logic in_valid;
    logic out_valid;
    logic w_in_valid;
    logic w_out_valid;
`endif

    order_sort_4 #(.DSIZE(8)) dut (
        .clock(clock), .rst(rst),
        .indata0(in0), .indata1(in1), .indata2(in2), .indata3(in3),
        .outdata0(out0), .outdata1(out1), .outdata2(out2), .outdata3(out3)
`ifdef ORDER_SORT_VALID_EN
        , .in_valid(in_valid), .out_valid(out_valid)
`endif
    );

    order_sort_4 #(.DSIZE(64)) dut64 (
        .clock(clock), .rst(rst),
        .indata0(w_in0), .indata1(w_in1), .indata2(w_in2), .indata3(w_in3),
        .outdata0(w_out0), .outdata1(w_out1), .outdata2(w_out2), .outdata3(w_out3)
`ifdef ORDER_SORT_VALID_EN
        , .in_valid(w_in_valid), .out_valid(w_out_valid)
`endif
    );

    typedef struct {
        logic [7:0] din [4];
        logic [7:0] dexp [4];
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    function automatic logic [31:0] outs();
        return {out3, out2, out1, out0};
    endfunction

    // Reference model: plain insertion sort on four bytes, lane 0 smallest.
    function automatic logic [31:0] sort4(input logic [31:0] v);
        logic [7:0] t [4];
        logic [7:0] k;
        int j;
        for (int i = 0; i < 4; i++) t[i] = v[i*8 +: 8];
        for (int i = 1; i < 4; i++) begin
            k = t[i];
            j = i - 1;
            while (j >= 0 && t[j] > k) begin
                t[j+1] = t[j];
                j--;
            end
            t[j+1] = k;
        end
        return {t[3], t[2], t[1], t[0]};
    endfunction

    vec_t        vecs [8];
    logic [31:0] hist [1000];
    logic [31:0] cur;
    logic        ordered;

    initial begin
        vecs[0] = '{din: '{8'd7,   8'd2,   8'd9,   8'd4},   dexp: '{8'd2,   8'd4,   8'd7,   8'd9}};
        vecs[1] = '{din: '{8'd10,  8'd8,   8'd3,   8'd0},   dexp: '{8'd0,   8'd3,   8'd8,   8'd10}};
        vecs[2] = '{din: '{8'd5,   8'd5,   8'd5,   8'd5},   dexp: '{8'd5,   8'd5,   8'd5,   8'd5}};
        vecs[3] = '{din: '{8'd255, 8'd0,   8'd255, 8'd0},   dexp: '{8'd0,   8'd0,   8'd255, 8'd255}};
        vecs[4] = '{din: '{8'd0,   8'd10,  8'd10,  8'd1},   dexp: '{8'd0,   8'd1,   8'd10,  8'd10}};
        vecs[5] = '{din: '{8'd0,   8'd0,   8'd0,   8'd0},   dexp: '{8'd0,   8'd0,   8'd0,   8'd0}};
        vecs[6] = '{din: '{8'd255, 8'd255, 8'd255, 8'd255}, dexp: '{8'd255, 8'd255, 8'd255, 8'd255}};
        vecs[7] = '{din: '{8'd1,   8'd2,   8'd3,   8'd4},   dexp: '{8'd1,   8'd2,   8'd3,   8'd4}};

        rst = 1'b1;
        drive(8'd5, 8'd3, 8'd9, 8'd1);
        w_in0 = '0; w_in1 = '0; w_in2 = '0; w_in3 = '0;
`ifdef ORDER_SORT_VALID_EN
        in_valid = 1'b0;
        w_in_valid = 1'b0;
`endif

        // Reset held: outputs stay zero whatever the inputs.
        repeat (3) tick();
        chk("reset_hold", {32'd0, outs()}, 64'd0);
        chk("reset_hold_w", w_out3, 64'd0);

        // Release reset; first set surfaces after the third edge.
        rst = 1'b0;
        tick();
        chk("post_rst_e0", {32'd0, outs()}, 64'd0);
        tick();
        chk("post_rst_e1", {32'd0, outs()}, 64'd0);
        tick();
        chk("post_rst_e2", {32'd0, outs()}, {32'd0, 8'd9, 8'd5, 8'd3, 8'd1});

        // Asynchronous reset between edges clears outputs immediately.
        #2 rst = 1'b1;
        #1 chk("async_rst", {32'd0, outs()}, 64'd0);
        #1 rst = 1'b0;

        // Directed table, inputs held long enough to fill the pipeline.
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].din[0], vecs[v].din[1], vecs[v].din[2], vecs[v].din[3]);
            repeat (3) tick();
            for (int l = 0; l < 4; l++) begin
                cur = outs();
                chk($sformatf("vec%0d_lane%0d", v, l), {56'd0, cur[l*8 +: 8]},
                    {56'd0, vecs[v].dexp[l]});
            end
        end

        // Mid-stream reset discards two in-flight sets.
        drive(8'd200, 8'd100, 8'd50, 8'd25);
        tick();
        drive(8'd9, 8'd8, 8'd9, 8'd8);
        tick();
        #2 rst = 1'b1;
        #1 chk("midstream_rst", {32'd0, outs()}, 64'd0);
        rst = 1'b0;
        drive(8'd3, 8'd2, 8'd1, 8'd0);
        tick();
        chk("flush_e0", {32'd0, outs()}, 64'd0);
        tick();
        chk("flush_e1", {32'd0, outs()}, 64'd0);
        tick();
        chk("flush_e2", {32'd0, outs()}, {32'd0, 8'd3, 8'd2, 8'd1, 8'd0});

        // Streaming: a fresh random set every cycle, scored against the set
        // sampled LAG edges before.
        for (int c = 0; c < 1000; c++) begin
            for (int l = 0; l < 4; l++) hist[c][l*8 +: 8] = 8'($urandom_range(0, 10));
            drive(hist[c][7:0], hist[c][15:8], hist[c][23:16], hist[c][31:24]);
            tick();
            if (c >= LAG) begin
                cur = outs();
                chk($sformatf("stream_%0d", c), {32'd0, cur}, {32'd0, sort4(hist[c-LAG])});
                ordered = (out0 <= out1) && (out1 <= out2) && (out2 <= out3);
                chk($sformatf("stream_order_%0d", c), {63'd0, ordered}, 64'd1);
            end
        end

        // Wide instance: unsigned full-width comparison.
        w_in0 = 64'h8000_0000_0000_0000;
        w_in1 = 64'd1;
        w_in2 = 64'hFFFF_FFFF_FFFF_FFFF;
        w_in3 = 64'd0;
        repeat (3) tick();
        chk("w64_lane0", w_out0, 64'd0);
        chk("w64_lane1", w_out1, 64'd1);
        chk("w64_lane2", w_out2, 64'h8000_0000_0000_0000);
        chk("w64_lane3", w_out3, 64'hFFFF_FFFF_FFFF_FFFF);

`ifdef ORDER_SORT_VALID_EN
        // Single valid pulse emerges exactly once, aligned with its data.
        drive(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) tick();
        drive(8'd4, 8'd3, 8'd2, 8'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drive(8'd0, 8'd0, 8'd0, 8'd0);
        chk("vld_e0", {63'd0, out_valid}, 64'd0);
        tick();
        chk("vld_e1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("vld_e2", {63'd0, out_valid}, 64'd1);
        chk("vld_data", {32'd0, outs()}, {32'd0, 8'd4, 8'd3, 8'd2, 8'd1});
        tick();
        chk("vld_e3", {63'd0, out_valid}, 64'd0);

        // Reset while a valid set is in flight: it never surfaces.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk($sformatf("vld_rst_e%0d", e), {63'd0, out_valid}, 64'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
